// File: rtl/crecomp_stream_bridge.sv
// rtl/crecomp_stream_bridge.sv - host stream to user core bridge with gather/scatter FIFOs
//
// Purpose: buffers host words in an input FIFO, gathers RCV_WORDS of them into
// one packed operand, starts the user core, waits for its done pulse (with an
// optional watchdog) and streams SND_WORDS result words into an output FIFO.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   din, wr_en, full      host write side of the input FIFO
//   dout, rd_en, empty    host read side of the output FIFO (dout registered)
//   user_din, user_start  packed operand and one-cycle start pulse to the core
//   user_busy             core busy (informational only)
//   user_done, user_dout  one-cycle result-ready pulse and packed result
//   in_level, out_level   FIFO occupancies
//   err                   sticky {timeout, underflow, overflow}
module crecomp_stream_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 512,
    parameter int RCV_WORDS      = 1,
    parameter int SND_WORDS      = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            wr_en,
    output logic                            full,
    output logic [DATA_WIDTH-1:0]           dout,
    input  logic                            rd_en,
    output logic                            empty,
    output logic [RCV_WORDS*DATA_WIDTH-1:0] user_din,
    output logic                            user_start,
    input  logic                            user_busy,
    input  logic                            user_done,
    input  logic [SND_WORDS*DATA_WIDTH-1:0] user_dout,
    output logic [$clog2(FIFO_DEPTH):0]     in_level,
    output logic [$clog2(FIFO_DEPTH):0]     out_level,
    output logic [2:0]                      err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = 5;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [IW-1:0] RCV_LAST = IW'(RCV_WORDS - 1);
    localparam logic [IW-1:0] SND_LAST = IW'(SND_WORDS - 1);
    localparam logic [31:0]   TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RCV, S_START, S_WAIT_DONE, S_SND, S_END
    } state_t;

    state_t state, state_next;

    // The core's busy flag carries no control meaning here.
    logic unused_busy;
    assign unused_busy = user_busy;

    // Input FIFO (first-word-fall-through toward the FSM)
    logic [DATA_WIDTH-1:0] in_mem [FIFO_DEPTH];
    logic [AW-1:0]         in_wr_ptr, in_rd_ptr;
    logic [LW-1:0]         in_count;
    logic                  in_push, in_pop;
    logic [DATA_WIDTH-1:0] in_data;

    // Output FIFO
    logic [DATA_WIDTH-1:0] out_mem [FIFO_DEPTH];
    logic [AW-1:0]         out_wr_ptr, out_rd_ptr;
    logic [LW-1:0]         out_count;
    logic                  out_push, out_pop, out_full;
    logic [DATA_WIDTH-1:0] out_wdata;

    logic [IW-1:0]                   idx;
    logic [31:0]                     tcnt;
    logic                            timeout_hit;
    logic [SND_WORDS*DATA_WIDTH-1:0] result;

    assign full      = (in_count == DEPTH_L);
    assign out_full  = (out_count == DEPTH_L);
    assign empty     = (out_count == '0);
    assign in_level  = in_count;
    assign out_level = out_count;
    assign in_push   = wr_en && !full;
    assign out_pop   = rd_en && !empty;
    assign in_data   = in_mem[in_rd_ptr];

    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= din;
        end
        if (out_push) begin
            out_mem[out_wr_ptr] <= out_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            dout       <= '0;
            err        <= '0;
        end else begin
            if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
            if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: in_count <= in_count;
            endcase

            if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
            if (out_pop) begin
                out_rd_ptr <= out_rd_ptr + 1'b1;
                dout       <= out_mem[out_rd_ptr];
            end
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + 1'b1;
                2'b01:   out_count <= out_count - 1'b1;
                default: out_count <= out_count;
            endcase

            if (wr_en && full)  err[0] <= 1'b1;
            if (rd_en && empty) err[1] <= 1'b1;
            if (timeout_hit)    err[2] <= 1'b1;
        end
    end

    // Result word selected by idx while streaming out.
    always_comb begin
        out_wdata = '0;
        for (int k = 0; k < SND_WORDS; k++) begin
            if (idx == IW'(k)) out_wdata = result[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_next  = state;
        in_pop      = 1'b0;
        out_push    = 1'b0;
        user_start  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_count != '0) state_next = S_RCV;
            end
            S_RCV: begin
                if (in_count != '0) begin
                    in_pop = 1'b1;
                    if (idx == RCV_LAST) state_next = S_START;
                end
            end
            S_START: begin
                user_start = 1'b1;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (user_done) begin
                    state_next = S_SND;
                end else if ((TIMEOUT_CYCLES > 0) && (tcnt == TO_LAST)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_END;
                end
            end
            S_SND: begin
                if (!out_full) begin
                    out_push = 1'b1;
                    if (idx == SND_LAST) state_next = S_END;
                end
            end
            S_END: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            tcnt     <= '0;
            user_din <= '0;
            result   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: idx <= '0;
                S_RCV: begin
                    if (in_pop) begin
                        for (int k = 0; k < RCV_WORDS; k++) begin
                            if (idx == IW'(k)) user_din[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        end
                        idx <= (idx == RCV_LAST) ? '0 : idx + 1'b1;
                    end
                end
                S_START: tcnt <= '0;
                S_WAIT_DONE: begin
                    tcnt <= tcnt + 1'b1;
                    if (user_done) begin
                        result <= user_dout;
                        idx    <= '0;
                    end
                end
                S_SND: begin
                    if (out_push) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crecomp_stream_bridge.sv
// tb/tb_crecomp_stream_bridge.sv - self-checking bench for crecomp_stream_bridge
module tb_crecomp_stream_bridge;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          full;
    logic [DW-1:0] dout;
    logic          rd_en;
    logic          empty;
    logic [63:0]   user_din;
    logic          user_start;
    logic          user_busy;
    logic          user_done;
    logic [63:0]   user_dout;
    logic [LW-1:0] in_level;
    logic [LW-1:0] out_level;
    logic [2:0]    err;

    logic        core_done, man_done, core_hold, use_fixed;
    logic [63:0] fixed_resp;
    logic [63:0] cap_q[$];
    int          start_cnt;
    int          checks, errors;

    assign user_done = core_done | man_done;
    assign user_busy = 1'b0;

    crecomp_stream_bridge #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RCV_WORDS(2), .SND_WORDS(2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
        .dout(dout), .rd_en(rd_en), .empty(empty), .user_din(user_din),
        .user_start(user_start), .user_busy(user_busy), .user_done(user_done),
        .user_dout(user_dout), .in_level(in_level), .out_level(out_level), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] resp_of(input logic [63:0] op);
        return {op[31:0] + 32'h1, op[63:32] ^ 32'h5A5A5A5A};
    endfunction

    initial begin
        start_cnt = 0;
        forever begin
            @(negedge clk);
            if (user_start) start_cnt++;
        end
    end

    // Behavioural user core: answers each start after 1..4 cycles unless held.
    initial begin
        logic [63:0] resp;
        core_done = 1'b0;
        user_dout = '0;
        forever begin
            @(negedge clk);
            if (user_start && !rst) begin
                cap_q.push_back(user_din);
                if (!core_hold) begin
                    resp = use_fixed ? fixed_resp : resp_of(user_din);
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    user_dout = resp;
                    core_done = 1'b1;
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; man_done = 1'b0; din = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cap_q.delete();
    endtask

    task automatic write_word(input logic [31:0] d);
        din = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_word(output logic [31:0] d);
        int n = 0;
        while (empty && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (empty) begin
            checks++; errors++;
            $display("FAIL read_wait: empty got 1 expected 0 within 300 cycles");
            d = '0;
        end else begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            d = dout;
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (!user_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", user_start, 1'b1);
    endtask

    task automatic wait_out_level(input int lvl);
        int n = 0;
        while (out_level != LW'(lvl) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("out_level_reach", out_level, lvl);
    endtask

    task automatic check_cap(input string name, input logic [63:0] exp);
        if (cap_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: no operand captured, expected %h", name, exp);
        end else begin
            check(name, cap_q.pop_front(), exp);
        end
    endtask

    typedef struct {
        logic [31:0] w0, w1;
        logic [63:0] resp;
        logic [63:0] exp_op;
        logic [31:0] exp_r0, exp_r1;
    } vec_t;

    initial begin
        vec_t        vt[4];
        logic [31:0] r;
        logic [31:0] exp_out[$];
        logic [63:0] exp_ops[$];
        logic [31:0] mdl_in[$];
        logic [63:0] op;
        int          s0, cyc, written, iter;
        bit          rd_pend, wr, rd;

        checks = 0; errors = 0;
        core_hold = 1'b0; use_fixed = 1'b1; fixed_resp = '0; man_done = 1'b0;

        vt[0] = '{32'h11111111, 32'h22222222, 64'h0000BBBB_0000AAAA, 64'h22222222_11111111, 32'h0000AAAA, 32'h0000BBBB};
        vt[1] = '{32'hDEADBEEF, 32'h01234567, 64'hCAFEF00D_12345678, 64'h01234567_DEADBEEF, 32'h12345678, 32'hCAFEF00D};
        vt[2] = '{32'h00000000, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 32'h00000000, 32'hFFFFFFFF};
        vt[3] = '{32'h80000001, 32'h7FFFFFFE, 64'h55555555_AAAAAAAA, 64'h7FFFFFFE_80000001, 32'hAAAAAAAA, 32'h55555555};

        // Reset state
        do_reset();
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_dout", dout, 0);
        check("rst_levels", {in_level, out_level}, 0);
        check("rst_user_din", user_din, 0);
        check("rst_user_start", user_start, 1'b0);
        check("rst_err", err, 0);

        // Table-driven transactions
        for (int i = 0; i < 4; i++) begin
            fixed_resp = vt[i].resp;
            s0 = start_cnt;
            write_word(vt[i].w0);
            write_word(vt[i].w1);
            read_word(r);
            check($sformatf("tbl%0d_r0", i), r, vt[i].exp_r0);
            read_word(r);
            check($sformatf("tbl%0d_r1", i), r, vt[i].exp_r1);
            @(negedge clk);
            check($sformatf("tbl%0d_empty", i), empty, 1'b1);
            check($sformatf("tbl%0d_starts", i), start_cnt - s0, 1);
            check_cap($sformatf("tbl%0d_op", i), vt[i].exp_op);
            check($sformatf("tbl%0d_din_held", i), user_din, vt[i].exp_op);
        end
        check("tbl_err", err, 0);

        // Underflow right after reset
        do_reset();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("uf_dout", dout, 0);
        check("uf_err", err, 3'b010);
        check("uf_empty", empty, 1'b1);

        // Overflow: core held after two words are gathered
        do_reset();
        core_hold = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) write_word(32'h100 + i);
        check("ovf_full", full, 1'b1);
        check("ovf_level_pre", in_level, DEPTH);
        check("ovf_err_pre", err, 0);
        write_word(32'hDEADBEEF);
        check("ovf_err", err, 3'b001);
        check("ovf_level", in_level, DEPTH);
        check("ovf_full_post", full, 1'b1);

        // Watchdog timeout
        do_reset();
        core_hold = 1'b1;
        write_word(32'hAAAA0001);
        write_word(32'hAAAA0002);
        wait_start();
        cyc = 0;
        while (!err[2] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("to_cycles", cyc, 101);
        check("to_err", err, 3'b100);
        repeat (3) @(negedge clk);
        check("to_empty", empty, 1'b1);
        check("to_out_level", out_level, 0);
        core_hold = 1'b0;
        use_fixed = 1'b1;
        fixed_resp = 64'h0BAD0002_0BAD0001;
        write_word(32'h33333333);
        write_word(32'h44444444);
        read_word(r);
        check("to_next_r0", r, 32'h0BAD0001);
        read_word(r);
        check("to_next_r1", r, 32'h0BAD0002);
        check("to_err_sticky", err, 3'b100);

        // Output FIFO backpressure
        do_reset();
        use_fixed = 1'b0;
        exp_out.delete();
        for (int t = 0; t < 4; t++) begin
            write_word(32'h1000 + 2 * t);
            write_word(32'h1000 + 2 * t + 1);
            op = {32'h1000 + 2 * t + 1, 32'h1000 + 2 * t};
            op = resp_of(op);
            exp_out.push_back(op[31:0]);
            exp_out.push_back(op[63:32]);
        end
        wait_out_level(DEPTH);
        read_word(r);
        check("bp_first", r, exp_out.pop_front());
        check("bp_level7", out_level, DEPTH - 1);
        write_word(32'h2000);
        write_word(32'h2001);
        op = resp_of({32'h2001, 32'h2000});
        exp_out.push_back(op[31:0]);
        exp_out.push_back(op[63:32]);
        wait_out_level(DEPTH);
        repeat (10) @(negedge clk);
        check("bp_stall_level", out_level, DEPTH);
        read_word(r);
        check("bp_second", r, exp_out.pop_front());
        repeat (3) @(negedge clk);
        check("bp_refill", out_level, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            read_word(r);
            check($sformatf("bp_drain%0d", i), r, exp_out.pop_front());
        end
        check("bp_empty", empty, 1'b1);
        check("bp_err", err, 0);

        // Reset during WAIT_DONE with words queued
        do_reset();
        core_hold = 1'b1;
        write_word(32'h55550000);
        write_word(32'h55550001);
        wait_start();
        @(negedge clk);
        write_word(32'h1);
        write_word(32'h2);
        write_word(32'h3);
        check("rw_level_pre", in_level, 3);
        s0 = start_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("rw_in_level", in_level, 0);
        check("rw_empty", empty, 1'b1);
        check("rw_start", user_start, 1'b0);
        check("rw_user_din", user_din, 0);
        rst = 1'b0;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (6) @(negedge clk);
        check("rw_late_done_empty", empty, 1'b1);
        check("rw_no_start", start_cnt - s0, 0);
        core_hold = 1'b0;
        use_fixed = 1'b1;
        fixed_resp = 64'h77777777_66666666;
        write_word(32'h9);
        write_word(32'hA);
        read_word(r);
        check("rw_next_r0", r, 32'h66666666);
        read_word(r);
        check("rw_next_r1", r, 32'h77777777);
        check("rw_err", err, 0);

        // Randomized traffic against a queue-based model
        do_reset();
        use_fixed = 1'b0;
        exp_out.delete(); exp_ops.delete(); mdl_in.delete();
        written = 0; iter = 0; rd_pend = 0;
        while (iter < 4000 && (written < 80 || exp_out.size() > 0 || rd_pend)) begin
            if (rd_pend) begin
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rnd_extra: got %h expected no data", dout);
                end else begin
                    check("rnd_dout", dout, exp_out.pop_front());
                end
            end
            wr = ($urandom_range(0, 2) != 0) && !full && (written < 80);
            rd = ($urandom_range(0, 1) != 0) && !empty;
            din = $urandom;
            wr_en = wr;
            rd_en = rd;
            rd_pend = rd;
            if (wr) begin
                written++;
                mdl_in.push_back(din);
                if (mdl_in.size() == 2) begin
                    op = {mdl_in[1], mdl_in[0]};
                    mdl_in.delete();
                    exp_ops.push_back(op);
                    op = resp_of(op);
                    exp_out.push_back(op[31:0]);
                    exp_out.push_back(op[63:32]);
                end
            end
            @(negedge clk);
            wr_en = 1'b0;
            rd_en = 1'b0;
            iter++;
        end
        check("rnd_drained", exp_out.size(), 0);
        check("rnd_op_count", cap_q.size(), exp_ops.size());
        while (cap_q.size() > 0 && exp_ops.size() > 0) check("rnd_op", cap_q.pop_front(), exp_ops.pop_front());
        check("rnd_err", err, 0);
        check("rnd_empty", empty, 1'b1);
        check("rnd_in_level", in_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
